muldiv_unit: RTL and testbench



---
 rtl/muldiv_pkg.sv | 31 +++
 rtl/muldiv_if.sv | 28 ++
 rtl/muldiv_step.sv | 32 +++
 rtl/muldiv_unit.sv | 169 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
// Shared op codes, FSM encoding and constants for the iterative
// multiply/divide unit beside the EX-stage ALU.
package muldiv_pkg;

    localparam int OP_W     = 3;
    localparam int MAX_XLEN = 128;

    localparam logic [OP_W-1:0] OP_MULT  = 3'b000;
    localparam logic [OP_W-1:0] OP_MULTU = 3'b001;
    localparam logic [OP_W-1:0] OP_DIV   = 3'b010;
    localparam logic [OP_W-1:0] OP_DIVU  = 3'b011;
    localparam logic [OP_W-1:0] OP_MTHI  = 3'b100;
    localparam logic [OP_W-1:0] OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    // LO after a divide by zero: all ones over the low xlen bits
    function automatic logic [MAX_XLEN-1:0] div0_lo(input int xlen);
        logic [MAX_XLEN-1:0] v;
        v = '0;
        for (int i = 0; i < MAX_XLEN; i++) begin
            if (i < xlen) v[i] = 1'b1;
        end
        return v;
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/result bundle between the EX stage and the multiply/divide
// unit; HI/LO are read continuously for MFHI/MFLO.
interface muldiv_if #(
    parameter int XLEN = 32
);
    import muldiv_pkg::*;

    logic            start;
    logic [OP_W-1:0] op;
    logic [XLEN-1:0] x;
    logic [XLEN-1:0] y;
    logic            flush;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;

    modport master (
        output start, op, x, y, flush,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, x, y, flush,
        output busy, done, hi, lo
    );

endinterface

// File: rtl/muldiv_step.sv
// One radix-2 iteration: right-shifting shift-add for multiply,
// left-shifting restoring shift-subtract for divide.
module muldiv_step #(
    parameter int XLEN = 32
) (
    input  logic              i_div,
    input  logic [2*XLEN-1:0] i_acc,
    input  logic [XLEN-1:0]   i_opnd,
    output logic [2*XLEN-1:0] o_acc
);

    logic [XLEN:0] w_sum;
    logic [XLEN:0] w_rsh;
    logic [XLEN:0] w_diff;

    always_comb begin
        w_sum  = {1'b0, i_acc[2*XLEN-1:XLEN]}
               + (i_acc[0] ? {1'b0, i_opnd} : '0);
        w_rsh  = {i_acc[2*XLEN-1:XLEN], i_acc[XLEN-1]};
        w_diff = w_rsh - {1'b0, i_opnd};
        o_acc  = {w_sum, i_acc[XLEN-1:1]};
        if (i_div) begin
            // remainder < divisor, so bit XLEN of the difference is the borrow
            if (!w_diff[XLEN]) begin
                o_acc = {w_diff[XLEN-1:0], i_acc[XLEN-2:0], 1'b1};
            end else begin
                o_acc = {w_rsh[XLEN-1:0], i_acc[XLEN-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers and MTHI/MTLO;
// works on magnitudes and fixes signs in a final cycle.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic    clk,
    input  logic    rst_n,
    muldiv_if.slave bus
);

    localparam int              CW       = $clog2(XLEN);
    localparam logic [CW-1:0]   CNT_LAST = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] DZ_LO    = XLEN'(div0_lo(XLEN));

    state_t            r_state;
    state_t            w_next;
    logic              r_done;
    logic              w_done;
    logic              w_accept;
    logic              w_mthi;
    logic              w_mtlo;

    logic [CW-1:0]     r_cnt;
    logic [2*XLEN-1:0] r_acc;
    logic [2*XLEN-1:0] w_acc_step;
    logic [XLEN-1:0]   r_opnd;
    logic              r_div;
    logic              r_negq;
    logic              r_negr;
    logic              r_dz;
    logic [XLEN-1:0]   r_hi;
    logic [XLEN-1:0]   r_lo;

    logic              w_is_md;
    logic              w_is_div;
    logic              w_signed;
    logic              w_sx;
    logic              w_sy;
    logic [XLEN-1:0]   w_xabs;
    logic [XLEN-1:0]   w_yabs;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_quot;
    logic [XLEN-1:0]   w_rem;
    logic [XLEN-1:0]   w_res_hi;
    logic [XLEN-1:0]   w_res_lo;

    always_comb begin
        w_is_md  = ~bus.op[2];
        w_is_div = bus.op[1];
        w_signed = ~bus.op[0];
        w_sx     = w_signed & bus.x[XLEN-1];
        w_sy     = w_signed & bus.y[XLEN-1];
        w_xabs   = w_sx ? -bus.x : bus.x;
        w_yabs   = w_sy ? -bus.y : bus.y;
    end

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_mthi   = 1'b0;
        w_mtlo   = 1'b0;
        w_done   = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (bus.start && !bus.flush) begin
                    unique case (1'b1)
                        w_is_md: begin
                            w_accept = 1'b1;
                            w_next   = ST_RUN;
                        end
                        (bus.op == OP_MTHI): w_mthi = 1'b1;
                        (bus.op == OP_MTLO): w_mtlo = 1'b1;
                        default: ;
                    endcase
                end
            end
            ST_RUN: begin
                if (bus.flush) begin
                    w_next = ST_IDLE;
                end else if (r_cnt == CNT_LAST) begin
                    w_next = ST_FIX;
                end
            end
            ST_FIX: begin
                w_next = ST_IDLE;
                w_done = ~bus.flush;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_done  <= w_done;
        end
    end

    muldiv_step #(
        .XLEN (XLEN)
    ) u_step (
        .i_div  (r_div),
        .i_acc  (r_acc),
        .i_opnd (r_opnd),
        .o_acc  (w_acc_step)
    );

    // Multiply keeps the multiplier in the low half; divide the dividend
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc  <= '0;
            r_opnd <= '0;
            r_cnt  <= '0;
            r_div  <= 1'b0;
            r_negq <= 1'b0;
            r_negr <= 1'b0;
            r_dz   <= 1'b0;
        end else if (w_accept) begin
            r_acc  <= {{XLEN{1'b0}}, (w_is_div ? w_xabs : w_yabs)};
            r_opnd <= w_is_div ? w_yabs : w_xabs;
            r_cnt  <= '0;
            r_div  <= w_is_div;
            r_negq <= w_sx ^ w_sy;
            r_negr <= w_sx & w_is_div;
            r_dz   <= w_is_div & (bus.y == '0);
        end else if (r_state == ST_RUN) begin
            r_acc  <= w_acc_step;
            r_cnt  <= r_cnt + 1'b1;
        end
    end

    // A zero divisor leaves |x| as remainder, so only LO needs forcing
    always_comb begin
        w_prod   = r_negq ? -r_acc : r_acc;
        w_quot   = r_acc[XLEN-1:0];
        w_rem    = r_acc[2*XLEN-1:XLEN];
        w_res_hi = w_prod[2*XLEN-1:XLEN];
        w_res_lo = w_prod[XLEN-1:0];
        if (r_div) begin
            w_res_hi = r_negr ? -w_rem : w_rem;
            w_res_lo = r_dz ? DZ_LO : (r_negq ? -w_quot : w_quot);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hi <= '0;
            r_lo <= '0;
        end else begin
            if (w_mthi) r_hi <= bus.x;
            if (w_mtlo) r_lo <= bus.x;
            if (w_done) begin
                r_hi <= w_res_hi;
                r_lo <= w_res_lo;
            end
        end
    end

    assign bus.busy = (r_state != ST_IDLE);
    assign bus.done = r_done;
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit: latency, results, back-to-back
// issue, divide corner cases, flush, MT writes and async reset.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    muldiv_if #(.XLEN(32)) bus ();

    muldiv_unit #(
        .XLEN (32)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge of the done cycle
    task automatic do_op(input string tag, input logic [2:0] o,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ehi, input logic [31:0] elo);
        int n;
        bus.start = 1'b1;
        bus.op    = o;
        bus.x     = a;
        bus.y     = b;
        @(negedge clk);
        bus.start = 1'b0;
        bus.op    = 3'b111;
        bus.x     = 32'hDEAD_BEEF;
        bus.y     = 32'h0BAD_F00D;
        n = 0;
        while (bus.busy && n < 100) begin
            n++;
            @(negedge clk);
        end
        check({tag, "_lat"}, 64'(n), 64'd33);
        check({tag, "_done"}, 64'(bus.done), 64'd1);
        check({tag, "_hi"}, 64'(bus.hi), 64'(ehi));
        check({tag, "_lo"}, 64'(bus.lo), 64'(elo));
    endtask

    task automatic mt(input logic [2:0] o, input logic [31:0] v,
                      input logic fl);
        bus.start = 1'b1;
        bus.op    = o;
        bus.x     = v;
        bus.flush = fl;
        @(negedge clk);
        bus.start = 1'b0;
        bus.flush = 1'b0;
    endtask

    initial begin
        int nd;
        n_vec     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.op    = 3'b000;
        bus.x     = '0;
        bus.y     = '0;
        bus.flush = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_hi", 64'(bus.hi), 64'd0);
        check("rst_lo", 64'(bus.lo), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        do_op("mult", OP_MULT, 32'hFFFF_FFFD, 32'd7,
              32'hFFFF_FFFF, 32'hFFFF_FFEB);
        @(negedge clk);
        check("mult_pulse", 64'(bus.done), 64'd0);
        do_op("multu", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
              32'hFFFF_FFFE, 32'h0000_0001);
        @(negedge clk);

        do_op("div", OP_DIV, 32'hFFFF_FFF9, 32'd2,
              32'hFFFF_FFFF, 32'hFFFF_FFFD);
        do_op("divu_b2b", OP_DIVU, 32'd7, 32'd2, 32'd1, 32'd3);
        @(negedge clk);
        do_op("div_negy", OP_DIV, 32'd7, 32'hFFFF_FFFE,
              32'd1, 32'hFFFF_FFFD);
        @(negedge clk);
        do_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF,
              32'd0, 32'h8000_0000);
        @(negedge clk);
        do_op("divu_z", OP_DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF);
        @(negedge clk);
        do_op("div_z", OP_DIV, 32'hFFFF_FFFB, 32'd0,
              32'hFFFF_FFFB, 32'hFFFF_FFFF);
        @(negedge clk);

        mt(OP_MTHI, 32'h11, 1'b0);
        mt(OP_MTLO, 32'h22, 1'b0);
        check("mt_hi", 64'(bus.hi), 64'h11);
        check("mt_lo", 64'(bus.lo), 64'h22);

        bus.start = 1'b1;
        bus.op    = OP_MULT;
        bus.x     = 32'd100;
        bus.y     = 32'd200;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        mt(OP_MTHI, 32'h99, 1'b0);
        repeat (4) @(negedge clk);
        check("run_busy", 64'(bus.busy), 64'd1);
        check("run_mt_ign", 64'(bus.hi), 64'h11);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        check("flush_busy", 64'(bus.busy), 64'd0);
        nd = 0;
        repeat (40) begin
            if (bus.done) nd++;
            @(negedge clk);
        end
        check("flush_nodone", 64'(nd), 64'd0);
        check("flush_hi", 64'(bus.hi), 64'h11);
        check("flush_lo", 64'(bus.lo), 64'h22);

        mt(OP_MTHI, 32'hABCD, 1'b0);
        check("mthi_hi", 64'(bus.hi), 64'hABCD);
        check("mthi_lo", 64'(bus.lo), 64'h22);
        check("mthi_busy", 64'(bus.busy), 64'd0);
        check("mthi_done", 64'(bus.done), 64'd0);
        mt(OP_MTLO, 32'h5555, 1'b1);
        check("mtlo_flush", 64'(bus.lo), 64'h22);
        mt(3'b110, 32'h7777, 1'b0);
        check("rsv_busy", 64'(bus.busy), 64'd0);
        check("rsv_hi", 64'(bus.hi), 64'hABCD);
        check("rsv_lo", 64'(bus.lo), 64'h22);

        bus.start = 1'b1;
        bus.op    = OP_MULT;
        bus.x     = 32'd2;
        bus.y     = 32'd3;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", 64'(bus.busy), 64'd0);
        check("arst_done", 64'(bus.done), 64'd0);
        check("arst_hi", 64'(bus.hi), 64'd0);
        check("arst_lo", 64'(bus.lo), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_op("post_rst", OP_MULTU, 32'd3, 32'd5, 32'd0, 32'd15);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
